load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage controller between the ALU (effective-address source) and the 32-word data memory. It accepts one load or store per request and performs byte, halfword and word accesses against the word-wide memory. Sub-word stores use read-modify-write. Loads return sign- or zero-extended data to the writeback path, and misaligned or illegal accesses are flagged without touching memory.

## Interface
- MEM_AW, 5: word-address width of the data memory (depth 2^MEM_AW words).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  access request from the execute stage; sampled only while ready=1.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- unsigned_ld  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; byte or halfword taken from the low bits.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid with done and held until the next done.
- fault  out  1  valid with done: misaligned access or illegal size.
- mem_addr  out  MEM_AW  word index, addr[MEM_AW+1:2].
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory read data, valid the cycle after mem_re.

## Operation
- Byte order is big-endian.
  - Byte offset k occupies bits [31-8k:24-8k].
  - Halfword offset 0 occupies [31:16]; offset 2 occupies [15:0].
- On acceptance (IDLE, req=1), is_store, size, unsigned_ld, addr and wdata are latched. Later input changes are ignored.
- Fault conditions:
  - size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00.
- A faulting request goes straight to DONE with fault=1. There is no mem_re or mem_we, and rdata is unchanged.
- addr bits above MEM_AW+1 are ignored (address wraps modulo memory size).
- States:
  - IDLE → DONE on fault; → WR for a word store; → RD otherwise.
  - RD: mem_re=1 → CAP.
  - CAP: capture mem_rdata.
    - Load: extend the selected lane into rdata → DONE.
    - Sub-word store: merge the wdata lane into the captured word → WR.
  - WR: mem_we=1, mem_wdata = merged word (or wdata for a word store) → DONE.
  - DONE: done=1 → IDLE.
- mem_addr is driven from the latched address in every non-IDLE state.
- req while ready=0 is ignored; upstream holds req until it sees ready.

## Timing
- Reset values: state IDLE, ready=1, done=0, fault=0, rdata=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0.
- Request accepted at edge T. done is high during cycle:
  - T+1 for a fault;
  - T+2 for a word store;
  - T+3 for any load;
  - T+4 for a sub-word store.
- Throughput: a new request can be accepted in the cycle after done (IDLE).
- mem_re and mem_we are each high for exactly one cycle per access and are never high together.
- Reset asserted mid-operation: all outputs take reset values immediately. A pending write (state RD or CAP) is never issued, and no done is produced.

## Structure
- Shared package (lsu_pkg): state enumeration (IDLE, RD, CAP, WR, DONE) and the size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
- Sub-module lsu_lane (combinational), performing:
  - load-lane extraction with sign/zero extension;
  - store-lane merge;
  - fault detection from size and addr[1:0].
- The top level holds the FSM, the request registers and the rdata register.

## Test plan
- Memory word 3 = 0x8899AABB; LW addr 0x0C → mem_re for one cycle with mem_addr=3; done at T+3; rdata=0x8899AABB; fault=0.
- LB addr 0x0D, unsigned_ld=0 → rdata=0xFFFFFF99. Repeat with unsigned_ld=1 → rdata=0x00000099. LH addr 0x0E, unsigned_ld=0 → rdata=0xFFFFAABB.
- SB addr 0x0E, wdata=0x12345677 → RD, then mem_we for one cycle with mem_wdata=0x889977BB and mem_addr=3; done at T+4.
- LW addr 0x0E and SH addr 0x0D → done at T+1, fault=1, no mem_re or mem_we, rdata unchanged.
- rst_n pulled low while an SB is in CAP → mem_we never asserts and memory word is unchanged. After release: ready=1; a following LW addr 0x0C returns 0x8899AABB.
- req held high through a busy SW addr 0x7C, wdata 0xDEADBEEF:
  - mem_addr=31, mem_wdata=0xDEADBEEF, done at T+2;
  - the next request is accepted only in the cycle after done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size codes and
// the helper that locates a lane inside a big-endian word.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Right-shift that brings the addressed lane down to bit 0 (big-endian:
    // byte offset 0 is the most significant byte).
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        logic [4:0] sh;
        case (size)
            SZ_BYTE: sh = {~off, 3'b000};
            SZ_HALF: sh = off[1] ? 5'd0 : 5'd16;
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: load extraction with sign/zero extension,
// sub-word store merge and alignment/size fault detection.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word,
    output logic        o_fault
);

    logic [4:0]  w_shift;
    logic [31:0] w_lane;
    logic [31:0] w_mask;
    logic        w_sign;

    always_comb begin
        w_shift = lane_shift(i_size, i_off);
        w_lane  = i_word >> w_shift;
        w_mask  = 32'hFFFF_FFFF;
        w_sign  = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                w_mask = 32'h0000_00FF;
                w_sign = w_lane[7];
            end
            SZ_HALF: begin
                w_mask = 32'h0000_FFFF;
                w_sign = w_lane[15];
            end
            default: ;
        endcase

        // For a word access ~w_mask is zero, so no extension bits are added
        o_ld_data = (w_lane & w_mask) | ((w_sign && !i_unsigned) ? ~w_mask : 32'h0);
        o_st_word = (i_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);

        case (i_size)
            SZ_HALF: o_fault = i_off[0];
            SZ_WORD: o_fault = |i_off;
            SZ_ILL:  o_fault = 1'b1;
            default: o_fault = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage controller: one load/store per request against a
// word-wide memory, with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t          r_state, w_next;
    logic [31:0]         r_rdata;
    logic                r_fault;
    logic                r_is_store;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [MEM_AW+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_wword;

    logic                w_accept;
    logic [1:0]          w_size;
    logic [1:0]          w_off;
    logic [31:0]         w_ld_data;
    logic [31:0]         w_st_word;
    logic                w_fault;
    logic                w_unused_addr;

    // Upper address bits only select beyond the memory and are wrapped away
    assign w_unused_addr = ^addr[31:MEM_AW+2];

    assign w_accept = (r_state == IDLE) && req;

    // Fault check uses live inputs in IDLE; extraction/merge use latched ones
    assign w_size = (r_state == IDLE) ? size      : r_size;
    assign w_off  = (r_state == IDLE) ? addr[1:0] : r_addr[1:0];

    lsu_lane u_lane (
        .i_size     (w_size),
        .i_off      (w_off),
        .i_unsigned (r_unsigned),
        .i_word     (mem_rdata),
        .i_wdata    (r_wdata),
        .o_ld_data  (w_ld_data),
        .o_st_word  (w_st_word),
        .o_fault    (w_fault)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_fault)
                        w_next = DONE;
                    else if (is_store && (size == SZ_WORD))
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD:      w_next = CAP;
            CAP:     w_next = r_is_store ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdata <= 32'h0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_fault <= w_fault;
            if ((r_state == CAP) && !r_is_store)
                r_rdata <= w_ld_data;
        end
    end

    // Request payload registers: only meaningful outside IDLE, never reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_store <= is_store;
            r_size     <= size;
            r_unsigned <= unsigned_ld;
            r_addr     <= addr[MEM_AW+1:0];
            r_wdata    <= wdata;
            r_wword    <= wdata;
        end else if ((r_state == CAP) && r_is_store) begin
            r_wword    <= w_st_word;
        end
    end

    assign ready     = (r_state == IDLE);
    assign done      = (r_state == DONE);
    assign fault     = done && r_fault;
    assign rdata     = r_rdata;
    assign mem_re    = (r_state == RD);
    assign mem_we    = (r_state == WR);
    assign mem_wdata = mem_we ? r_wword : 32'h0;
    assign mem_addr  = (r_state == IDLE) ? '0 : r_addr[MEM_AW+1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a 32-word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, fault, mem_re, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [4:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] tb_mem [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = 5'd0;
    logic [31:0] pre_data = 32'h0;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .is_store(is_store), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .ready(ready),
        .done(done), .rdata(rdata), .fault(fault), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) tb_mem[pre_addr] <= pre_data;
        else if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= tb_mem[mem_addr];
    end

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic        flt;
        int          nre;
        int          nwe;
        logic [4:0]  ma;
        logic [31:0] mwd;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready) return;
        end
        chk("ready_timeout", {31'h0, ready}, 32'h1);
    endtask

    task automatic run(input vec_t v, output int lat, output int nre, output int nwe,
                       output logic [4:0] ma, output logic [31:0] mwd,
                       output logic [31:0] rd, output logic flt);
        lat = -1; nre = 0; nwe = 0; ma = 5'h0; mwd = 32'h0; rd = 32'h0; flt = 1'b0;
        wait_ready();
        is_store = v.st; size = v.sz; unsigned_ld = v.uns; addr = v.a; wdata = v.wd; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        is_store = ~v.st; size = ~v.sz; unsigned_ld = ~v.uns; addr = 32'hFFFF_FFFF; wdata = ~v.wd;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_re) begin nre++; ma = mem_addr; end
            if (mem_we) begin nwe++; ma = mem_addr; mwd = mem_wdata; end
            if (mem_re && mem_we) chk("re_we_overlap", 32'h1, 32'h0);
            if (done) begin
                lat = c; rd = rdata; flt = fault;
                break;
            end
        end
    endtask

    initial begin
        int lat, nre, nwe;
        logic [4:0] ma;
        logic [31:0] mwd, rd;
        logic flt;
        string tag;

        //             st   sz     uns   addr          wdata         lat rdata         flt  re we ma     mwdata
        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        3, 32'h8899AABB, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0,        3, 32'hFFFFFF99, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'h0,        3, 32'h00000099, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'h0,        3, 32'hFFFFAABB, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_000C, 32'h0,        3, 32'h00008899, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[5]  = '{1'b1, 2'b00, 1'b0, 32'h0000_000E, 32'h12345677, 4, 32'h00008899, 1'b0, 1, 1, 5'd3,  32'h889977BB};
        vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        3, 32'h889977BB, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'h0,        1, 32'h889977BB, 1'b1, 0, 0, 5'd0,  32'h0};
        vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_000D, 32'h1111,     1, 32'h889977BB, 1'b1, 0, 0, 5'd0,  32'h0};
        vt[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_000C, 32'h0,        1, 32'h889977BB, 1'b1, 0, 0, 5'd0,  32'h0};
        vt[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_000E, 32'h0000CAFE, 4, 32'h889977BB, 1'b0, 1, 1, 5'd3,  32'h8899CAFE};
        vt[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_000F, 32'h0,        3, 32'hFFFFFFFE, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[12] = '{1'b1, 2'b00, 1'b0, 32'h0000_000C, 32'h000000AB, 4, 32'hFFFFFFFE, 1'b0, 1, 1, 5'd3,  32'hAB99CAFE};
        vt[13] = '{1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0,        3, 32'hFFFFFFAB, 1'b0, 1, 0, 5'd3,  32'h0};
        vt[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_007C, 32'hDEADBEEF, 2, 32'hFFFFFFAB, 1'b0, 0, 1, 5'd31, 32'hDEADBEEF};
        vt[15] = '{1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1, 0, 5'd31, 32'h0};
        vt[16] = '{1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0,        3, 32'h0000BEEF, 1'b0, 1, 0, 5'd31, 32'h0};

        // Outputs while held in reset
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_addr", {27'h0, mem_addr}, 32'h0);
        rst_n = 1'b1;

        poke(5'd3, 32'h8899AABB);
        poke(5'd31, 32'h0);

        for (int i = 0; i < 17; i++) begin
            run(vt[i], lat, nre, nwe, ma, mwd, rd, flt);
            tag = $sformatf("v%0d", i);
            chk({tag, "_latency"}, lat, vt[i].lat);
            chk({tag, "_fault"}, {31'h0, flt}, {31'h0, vt[i].flt});
            chk({tag, "_rdata"}, rd, vt[i].rd);
            chk({tag, "_re_count"}, nre, vt[i].nre);
            chk({tag, "_we_count"}, nwe, vt[i].nwe);
            if (vt[i].nre + vt[i].nwe > 0) chk({tag, "_mem_addr"}, {27'h0, ma}, {27'h0, vt[i].ma});
            if (vt[i].nwe > 0) chk({tag, "_mem_wdata"}, mwd, vt[i].mwd);
        end
        chk("mem31_after_sw", tb_mem[31], 32'hDEADBEEF);

        // Reset while a byte store sits in CAP
        poke(5'd3, 32'h8899AABB);
        wait_ready();
        is_store = 1'b1; size = 2'b00; unsigned_ld = 1'b0; addr = 32'h0E; wdata = 32'h12345600; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'h0, ready}, 32'h1);
        chk("midrst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("midrst_mem_addr", {27'h0, mem_addr}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        nwe = 0; nre = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (done) nre++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (done) nre++;
        end
        chk("midrst_no_write", nwe, 0);
        chk("midrst_no_done", nre, 0);
        chk("midrst_ready_after", {31'h0, ready}, 32'h1);
        chk("midrst_mem3", tb_mem[3], 32'h8899AABB);
        run(vt[0], lat, nre, nwe, ma, mwd, rd, flt);
        chk("postrst_lw_latency", lat, 3);
        chk("postrst_lw_rdata", rd, 32'h8899AABB);

        // req held high through a busy word store; the queued LW waits for IDLE
        poke(5'd31, 32'h0);
        wait_ready();
        is_store = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h7C; wdata = 32'hDEADBEEF; req = 1'b1;
        @(posedge clk);
        #1;
        is_store = 1'b0; size = 2'b10; addr = 32'h0C; wdata = 32'h0;
        @(negedge clk);
        chk("busy_t1_mem_we", {31'h0, mem_we}, 32'h1);
        chk("busy_t1_mem_addr", {27'h0, mem_addr}, 32'd31);
        chk("busy_t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("busy_t1_ready", {31'h0, ready}, 32'h0);
        @(negedge clk);
        chk("busy_t2_done", {31'h0, done}, 32'h1);
        chk("busy_t2_ready", {31'h0, ready}, 32'h0);
        @(negedge clk);
        chk("busy_t3_ready", {31'h0, ready}, 32'h1);
        chk("busy_t3_mem_re", {31'h0, mem_re}, 32'h0);
        @(negedge clk);
        req = 1'b0;
        chk("busy_t4_mem_re", {31'h0, mem_re}, 32'h1);
        chk("busy_t4_mem_addr", {27'h0, mem_addr}, 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("busy_lw_done", {31'h0, done}, 32'h1);
        chk("busy_lw_rdata", rdata, 32'h8899AABB);
        chk("busy_mem31", tb_mem[31], 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
